// File: rtl/qam16_encode_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : qam16_encode_if
// Description : Serial bit handshake and I/Q symbol bundle for qam16_encode.
// Revision    : 1.0 - initial release
// ============================================================================
interface qam16_encode_if #(
  parameter int OUT_WIDTH = 3
);
  logic                 bit_in;
  logic                 bit_valid;
  logic                 bit_ready;
  logic [OUT_WIDTH-1:0] inphase;
  logic [OUT_WIDTH-1:0] quad;
  logic                 iq_valid;
  logic [3:0]           symbol;
  logic                 sym_start;

  // master = encoder, slave = bit source / symbol sink
  modport master (
    input  bit_in, bit_valid,
    output bit_ready, inphase, quad, iq_valid, symbol, sym_start
  );
  modport slave (
    output bit_in, bit_valid,
    input  bit_ready, inphase, quad, iq_valid, symbol, sym_start
  );
endinterface
`default_nettype wire

// File: rtl/qam16_encode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : qam16_encode
// Description : 16-QAM mapper; packs serial bits MSB first into Gray-coded
//               I/Q levels, each symbol held for SYMBOL_PERIOD clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module qam16_encode #(
  parameter int OUT_WIDTH     = 3,
  parameter int SYMBOL_PERIOD = 4
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  qam16_encode_if.master bus
);

  localparam int              c_PER_W    = (SYMBOL_PERIOD > 1) ? $clog2(SYMBOL_PERIOD) : 1;
  localparam logic [c_PER_W-1:0] c_PER_LAST = c_PER_W'(SYMBOL_PERIOD - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t               r_state;
  logic [1:0]           r_bit_cnt;
  logic [2:0]           r_sr;
  logic [3:0]           r_pend;
  logic                 r_pend_full;
  logic [c_PER_W-1:0]   r_per_cnt;
  logic [OUT_WIDTH-1:0] r_inphase;
  logic [OUT_WIDTH-1:0] r_quad;
  logic [3:0]           r_symbol;
  logic                 r_iq_valid;
  logic                 r_sym_start;

  logic w_ready;
  logic w_accept;
  logic w_load;

  // Ready only blocks the 4th bit while the previous symbol is still pending,
  // so pend is never written and consumed on the same edge.
  assign w_ready  = !(r_pend_full && (r_bit_cnt == 2'd3));
  assign w_accept = bus.bit_valid && w_ready;
  assign w_load   = r_pend_full && ((r_state == S_IDLE) || (r_per_cnt == c_PER_LAST));

  function automatic logic [OUT_WIDTH-1:0] f_map(input logic [1:0] i_f);
    logic signed [2:0]           w_lvl;
    logic signed [OUT_WIDTH-1:0] w_ext;
    case (i_f)
      2'b00:   w_lvl = 3'sb101;
      2'b01:   w_lvl = 3'sb111;
      2'b11:   w_lvl = 3'sb001;
      default: w_lvl = 3'sb011;
    endcase
    w_ext = OUT_WIDTH'(w_lvl);
    return w_ext;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt   <= 2'd0;
      r_sr        <= 3'd0;
      r_pend      <= 4'd0;
      r_pend_full <= 1'b0;
    end else begin
      if (w_load) begin
        r_pend_full <= 1'b0;
      end
      if (w_accept) begin
        if (r_bit_cnt == 2'd3) begin
          r_pend      <= {r_sr, bus.bit_in};
          r_pend_full <= 1'b1;
        end
        r_sr      <= {r_sr[1:0], bus.bit_in};
        r_bit_cnt <= r_bit_cnt + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_per_cnt   <= '0;
      r_inphase   <= '0;
      r_quad      <= '0;
      r_symbol    <= 4'd0;
      r_iq_valid  <= 1'b0;
      r_sym_start <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_pend_full) begin
            r_state     <= S_SEND;
            r_per_cnt   <= '0;
            r_symbol    <= r_pend;
            r_inphase   <= f_map(r_pend[3:2]);
            r_quad      <= f_map(r_pend[1:0]);
            r_iq_valid  <= 1'b1;
            r_sym_start <= 1'b1;
          end else begin
            r_sym_start <= 1'b0;
          end
        end
        default: begin
          if (r_per_cnt != c_PER_LAST) begin
            r_per_cnt   <= r_per_cnt + c_PER_W'(1);
            r_sym_start <= 1'b0;
          end else if (r_pend_full) begin
            r_per_cnt   <= '0;
            r_symbol    <= r_pend;
            r_inphase   <= f_map(r_pend[3:2]);
            r_quad      <= f_map(r_pend[1:0]);
            r_iq_valid  <= 1'b1;
            r_sym_start <= 1'b1;
          end else begin
            r_state     <= S_IDLE;
            r_per_cnt   <= '0;
            r_inphase   <= '0;
            r_quad      <= '0;
            r_symbol    <= 4'd0;
            r_iq_valid  <= 1'b0;
            r_sym_start <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.bit_ready = w_ready;
  assign bus.inphase   = r_inphase;
  assign bus.quad      = r_quad;
  assign bus.iq_valid  = r_iq_valid;
  assign bus.symbol    = r_symbol;
  assign bus.sym_start = r_sym_start;

endmodule
`default_nettype wire

// File: doc/qam16_encode.md
# qam16_encode

16-QAM symbol encoder (modulator mapper) for the transmit side of the 16-QAM link. It accepts a serial bit stream through a valid/ready handshake and packs it four bits per symbol, MSB first. Each symbol is mapped to Gray-coded signed I/Q levels in {-3,-1,+1,+3}, and each level pair is held for a programmable number of clocks. The mapping is the exact inverse of the team's 16-QAM symbol decoder, so the encoder and decoder chained back-to-back must return the original 4-bit symbols.

## Interface
- OUT_WIDTH, 3: width of inphase/quad; two's complement; the level is sign-extended when OUT_WIDTH > 3; minimum 3.
- SYMBOL_PERIOD, 4: clocks each symbol is held on the outputs; minimum 1.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- bit_in  input  1  serial data bit.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_ready  output  1  encoder can accept a bit this cycle.
- inphase  output  OUT_WIDTH  I level, signed.
- quad  output  OUT_WIDTH  Q level, signed.
- iq_valid  output  1  inphase/quad carry a symbol.
- symbol  output  4  symbol currently on the outputs (debug/loopback).
- sym_start  output  1  one-cycle pulse on the first cycle of each symbol.

## Operation
- **Bit acceptance:** a bit is accepted on a rising edge only when bit_valid && bit_ready.
  - When bit_valid=1 and bit_ready=0, the bit is not taken and the source must hold it.
- **Assembler:** 2-bit counter bit_cnt and 3-bit shift register sr.
  - Accepted bits shift in MSB first: the first bit becomes symbol[3], the fourth becomes symbol[0].
  - On the fourth accept, {sr, bit_in} is written to register pend, pend_full is set to 1, and bit_cnt wraps to 0.
- **Ready rule:** bit_ready = !(pend_full && bit_cnt==3), decoded from registers only.
  - Bits 1-3 of the next symbol may be collected while pend is full.
  - The pend write (needs pend_full=0) and the pend consume (needs pend_full=1) therefore never occur on the same edge.
- **Gray map per 2-bit field:** 00 → -3 (3'b101), 01 → -1 (3'b111), 11 → +1 (3'b001), 10 → +3 (3'b011).
  - inphase = map(symbol[3:2]); quad = map(symbol[1:0]).
- **Transmitter FSM, states IDLE and SEND; period counter per_cnt of width clog2(SYMBOL_PERIOD), minimum 1 bit.**
  - IDLE, pend_full=1: load the output registers from pend, clear pend_full, per_cnt←0, iq_valid←1, sym_start←1, go to SEND.
  - IDLE, pend_full=0: stay in IDLE.
  - SEND, per_cnt < SYMBOL_PERIOD-1: per_cnt increments; outputs hold; sym_start←0.
  - SEND, per_cnt == SYMBOL_PERIOD-1, pend_full=1: load the next symbol exactly as from IDLE and stay in SEND. There is no gap.
  - SEND, per_cnt == SYMBOL_PERIOD-1, pend_full=0: go to IDLE; iq_valid←0; inphase, quad, symbol ← 0.
- **Underrun:** whenever no symbol is held, the outputs are 0 with iq_valid=0. Partial bits stay in sr and are never flushed.
- **Reset (asynchronous, any cycle including mid-symbol):**
  - FSM→IDLE; bit_cnt, sr, pend, pend_full, per_cnt → 0.
  - inphase, quad, symbol → 0; iq_valid, sym_start → 0; bit_ready = 1.
  - Partially collected bits and the pending symbol are discarded.

## Timing
- All outputs are registered except bit_ready, which is combinational from registers only.
- **Latency:** the fourth bit is accepted at edge k. pend_full rises after k. Outputs become valid after edge k+1 when the FSM is IDLE, or at the next symbol boundary when it is in SEND.
- **Symbol duration:** each symbol holds for exactly SYMBOL_PERIOD cycles; sym_start is high for its first cycle only.
- **Throughput:** with SYMBOL_PERIOD ≥ 4 and bit_valid held high, iq_valid stays continuously high after the first symbol. bit_ready drops for SYMBOL_PERIOD-4 cycles per symbol.
- **SYMBOL_PERIOD < 4:** the source cannot keep up; iq_valid shows gaps and the underrun rules apply.
- **SYMBOL_PERIOD = 1:** per_cnt is always 0 and every cycle is a boundary.

## Test plan
1. **Reset:** assert rst_n=0, release, then idle 5 cycles → inphase=quad=0, symbol=0, iq_valid=0, sym_start=0, bit_ready=1.
2. **Single symbol:** send bits 1,0,1,1 with SYMBOL_PERIOD=4 → one cycle after the fourth accept, symbol=4'b1011, inphase=3'b011 (+3), quad=3'b001 (+1), iq_valid=1 for exactly 4 cycles, sym_start for 1 cycle, then all outputs return to 0.
3. **Exhaustive back-to-back:** symbols 0..15 sent MSB first with bit_valid held high, SYMBOL_PERIOD=4.
   - Each I/Q pair matches the Gray map, e.g. 0000→(-3,-3), 0110→(-1,+3), 1101→(+1,-1).
   - iq_valid stays high for 64 cycles with no gaps.
   - Feeding inphase/quad into a decoder model reproduces symbols 0..15 in order.
4. **Backpressure:** SYMBOL_PERIOD=8, bit_valid held high, random bits.
   - bit_ready is low 4 cycles per symbol.
   - No bit is lost or duplicated: the output symbol sequence equals the input bits grouped by 4.
   - iq_valid is continuous.
5. **Underrun:** send one symbol, wait 10 cycles, send a second.
   - iq_valid drops to 0 between the symbols with outputs 0.
   - sym_start pulses once per symbol.
   - Two bits sent and then stalled produce no output.
6. **Reset mid-operation:** assert rst_n during cycle 2 of a symbol with 2 bits already collected.
   - Outputs go to 0 immediately (asynchronously).
   - After release, 4 new bits 0,1,0,0 give symbol 0100 → (-1,-3), with no residue of the old bits.
